// File: rtl/ram_readback_if.sv
// ram_readback_if
// Bundles the two buses the read-back engine talks on:
//   - RAM side:    ram_addr / ram_write_en out to the program RAM, ram_data back
//                  (synchronous read, valid one edge after ram_addr changes).
//   - Stream side: out_data / out_addr / out_valid towards the display/LED path,
//                  out_ready back from the consumer.
// Modports:
//   master - the read-back engine (drives address, write enable and the stream).
//   slave  - the RAM plus consumer side (drives ram_data and out_ready).
interface ram_readback_if #(
  parameter int WORDSIZE = 8,
  parameter int ADDR_W   = 2
);
  logic [ADDR_W-1:0]   ram_addr;
  logic                ram_write_en;
  logic [WORDSIZE-1:0] ram_data;
  logic [WORDSIZE-1:0] out_data;
  logic [ADDR_W-1:0]   out_addr;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output ram_addr, ram_write_en, out_data, out_addr, out_valid,
    input  ram_data, out_ready
  );

  modport slave (
    input  ram_addr, ram_write_en, out_data, out_addr, out_valid,
    output ram_data, out_ready
  );
endinterface

// File: rtl/ram_readback.sv
// ram_readback
// Sequential read-back engine for the program RAM on the init_clock domain.
// A start pulse in IDLE walks COUNT consecutive addresses (wrapping) from
// START_ADDR, presents every word on a valid/ready stream and keeps a running
// checksum (mod 2^WORDSIZE) of the words the consumer accepted.
// Ports:
//   init_clock  - block clock, rising edge
//   init_reset  - asynchronous, active-high reset
//   i_start     - run request, only looked at in IDLE
//   bus         - ram_readback_if.master (RAM address/data + output stream)
//   o_busy      - high in every state except IDLE
//   o_done      - level: last run completed
//   o_checksum  - sum of accepted words in the current/last run
module ram_readback #(
  parameter int WORDSIZE   = 8,
  parameter int ADDR_W     = 2,
  parameter int START_ADDR = 0,
  parameter int COUNT      = 4
) (
  input  logic                init_clock,
  input  logic                init_reset,
  input  logic                i_start,
  ram_readback_if.master      bus,
  output logic                o_busy,
  output logic                o_done,
  output logic [WORDSIZE-1:0] o_checksum
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_PRESENT = 2'd3;

  localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(START_ADDR);
  // Index is one bit wider than the address so COUNT = 2^ADDR_W fits.
  localparam logic [ADDR_W:0]   LAST_IDX  = (ADDR_W+1)'(COUNT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   INDEX_ONE = (ADDR_W+1)'(1);

  logic [1:0]          r_state;
  logic [ADDR_W:0]     r_index;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [WORDSIZE-1:0] r_out_data;
  logic [ADDR_W-1:0]   r_out_addr;
  logic                r_out_valid;
  logic                r_busy;
  logic                r_done;
  logic [WORDSIZE-1:0] r_checksum;

  logic                w_handshake;
  logic                w_last;

  // Modular checksum step: the sum is simply truncated to WORDSIZE bits.
  function automatic logic [WORDSIZE-1:0] f_csum_add(
    input logic [WORDSIZE-1:0] i_sum,
    input logic [WORDSIZE-1:0] i_word
  );
    return i_sum + i_word;
  endfunction

  // Handshake and last-word decode.
  always_comb begin
    w_handshake = r_out_valid & bus.out_ready;
    w_last      = (r_index == LAST_IDX);
  end

  // Main sequencer; every output is a register updated here.
  always_ff @(posedge init_clock or posedge init_reset) begin
    if (init_reset) begin
      r_state     <= S_IDLE;
      r_index     <= '0;
      r_ram_addr  <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_checksum  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // done/checksum hold here until the next run is requested.
          if (i_start) begin
            r_ram_addr <= START_A;
            r_index    <= '0;
            r_checksum <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_WAIT;
          end else begin
            r_state    <= S_IDLE;
          end
        end
        S_WAIT: begin
          // RAM read latency: ram_data is valid for ram_addr on the next edge.
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_out_data  <= bus.ram_data;
          r_out_addr  <= r_ram_addr;
          r_out_valid <= 1'b1;
          r_state     <= S_PRESENT;
        end
        S_PRESENT: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_checksum  <= f_csum_add(r_checksum, r_out_data);
            if (w_last) begin
              // Back to IDLE; a start on this same edge is deliberately lost.
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_index    <= r_index + INDEX_ONE;
              r_ram_addr <= r_ram_addr + ADDR_ONE;
              r_state    <= S_WAIT;
            end
          end else begin
            // Backpressure: everything stays put, no timeout.
            r_state <= S_PRESENT;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_addr     = r_ram_addr;
  assign bus.ram_write_en = 1'b0;
  assign bus.out_data     = r_out_data;
  assign bus.out_addr     = r_out_addr;
  assign bus.out_valid    = r_out_valid;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_checksum       = r_checksum;

endmodule

// File: tb/tb_ram_readback.sv
module tb_ram_readback;

  logic       clk;
  logic       rst;
  logic       start_a;
  logic       start_b;
  logic       ready;
  logic       sel;
  logic       busy_a, done_a, busy_b, done_b;
  logic [7:0] csum_a, csum_b;
  logic [7:0] rd_a, rd_b;
  logic [7:0] mem [0:3];

  int n_tests;
  int n_fail;
  int hs_cnt;
  logic [9:0] q_exp [$];

  ram_readback_if #(.WORDSIZE(8), .ADDR_W(2)) if_a ();
  ram_readback_if #(.WORDSIZE(8), .ADDR_W(2)) if_b ();

  ram_readback #(.WORDSIZE(8), .ADDR_W(2), .START_ADDR(0), .COUNT(4)) dut_a (
    .init_clock (clk),
    .init_reset (rst),
    .i_start    (start_a),
    .bus        (if_a),
    .o_busy     (busy_a),
    .o_done     (done_a),
    .o_checksum (csum_a)
  );

  ram_readback #(.WORDSIZE(8), .ADDR_W(2), .START_ADDR(3), .COUNT(4)) dut_b (
    .init_clock (clk),
    .init_reset (rst),
    .i_start    (start_b),
    .bus        (if_b),
    .o_busy     (busy_b),
    .o_done     (done_b),
    .o_checksum (csum_b)
  );

  // Synchronous-read RAM model, one read port per engine.
  always @(posedge clk) begin
    rd_a <= mem[if_a.ram_addr];
    rd_b <= mem[if_b.ram_addr];
  end

  assign if_a.ram_data  = rd_a;
  assign if_b.ram_data  = rd_b;
  assign if_a.out_ready = ready;
  assign if_b.out_ready = ready;

  logic       busy_s, done_s, valid_s;
  logic [7:0] csum_s, data_s;
  logic [1:0] addr_s;
  assign busy_s  = sel ? busy_b : busy_a;
  assign done_s  = sel ? done_b : done_a;
  assign csum_s  = sel ? csum_b : csum_a;
  assign valid_s = sel ? if_b.out_valid : if_a.out_valid;
  assign data_s  = sel ? if_b.out_data : if_a.out_data;
  assign addr_s  = sel ? if_b.out_addr : if_a.out_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic take_word(input logic [1:0] a, input logic [7:0] d);
    logic [9:0] e;
    hs_cnt++;
    if (q_exp.size() == 0) begin
      check_val("extra_word", 32'd1, 32'd0);
    end else begin
      e = q_exp.pop_front();
      check_val("word_addr", {30'd0, a}, {30'd0, e[9:8]});
      check_val("word_data", {24'd0, d}, {24'd0, e[7:0]});
    end
  endtask

  // Scoreboard side: every accepted word is compared with the queue head.
  always @(negedge clk) begin
    if (!rst && if_a.out_valid && if_a.out_ready) take_word(if_a.out_addr, if_a.out_data);
    if (!rst && if_b.out_valid && if_b.out_ready) take_word(if_b.out_addr, if_b.out_data);
  end

  task automatic check_reset_state();
    check_val("rst_busy",  {31'd0, busy_a}, 32'd0);
    check_val("rst_done",  {31'd0, done_a}, 32'd0);
    check_val("rst_csum",  {24'd0, csum_a}, 32'd0);
    check_val("rst_valid", {31'd0, if_a.out_valid}, 32'd0);
    check_val("rst_odata", {24'd0, if_a.out_data}, 32'd0);
    check_val("rst_oaddr", {30'd0, if_a.out_addr}, 32'd0);
    check_val("rst_raddr", {30'd0, if_a.ram_addr}, 32'd0);
    check_val("rst_wen",   {31'd0, if_a.ram_write_en}, 32'd0);
  endtask

  task automatic push_expected(input int sa);
    int a;
    for (int i = 0; i < 4; i++) begin
      a = (sa + i) % 4;
      q_exp.push_back({a[1:0], mem[a]});
    end
  endtask

  // One complete run: stimulus, optional backpressure / stray start, final checks.
  task automatic run(input logic s, input int sa, input logic [7:0] exp_csum,
                     input int bp_len, input int restart_at);
    int cyc;
    sel    = s;
    hs_cnt = 0;
    ready  = 1'b1;
    push_expected(sa);
    @(posedge clk); #1;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    check_val("busy_after_start", {31'd0, busy_s}, 32'd1);
    check_val("done_cleared",     {31'd0, done_s}, 32'd0);
    cyc = 0;
    while (!done_s && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) check_val("no_valid_e1", {31'd0, valid_s}, 32'd0);
      if (cyc == 2) check_val("first_valid_e2", {31'd0, valid_s}, 32'd1);
      if (bp_len > 0 && cyc == 5) ready = 1'b0;
      if (bp_len > 0 && cyc == 5 + bp_len) ready = 1'b1;
      if (!ready) begin
        check_val("hold_valid", {31'd0, valid_s}, 32'd1);
        check_val("hold_addr",  {30'd0, addr_s}, 32'd1);
        check_val("hold_data",  {24'd0, data_s}, 32'd29);
      end
      if (restart_at > 0 && cyc == restart_at) begin
        if (s) start_b = 1'b1; else start_a = 1'b1;
      end
      if (restart_at > 0 && cyc == restart_at + 1) begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
    ready   = 1'b1;
    check_val("done_cycles", cyc, 12 + bp_len);
    check_val("done_level",  {31'd0, done_s}, 32'd1);
    check_val("busy_end",    {31'd0, busy_s}, 32'd0);
    check_val("checksum",    {24'd0, csum_s}, {24'd0, exp_csum});
    check_val("handshakes",  hs_cnt, 4);
    check_val("queue_left",  q_exp.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("no_restart",  {31'd0, busy_s}, 32'd0);
    check_val("done_holds",  {31'd0, done_s}, 32'd1);
    check_val("csum_holds",  {24'd0, csum_s}, {24'd0, exp_csum});
    check_val("wen_zero",    {30'd0, if_a.ram_write_en, if_b.ram_write_en}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    hs_cnt  = 0;
    sel     = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    ready   = 1'b1;
    mem[0] = 8'd74; mem[1] = 8'd29; mem[2] = 8'd32; mem[3] = 8'd20;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic read-back, wrap-around, backpressure.
    run(1'b0, 0, 8'd155, 0, 0);
    run(1'b1, 3, 8'd155, 0, 0);
    run(1'b0, 0, 8'd155, 5, 0);
    // Start during PRESENT of word 1, and on the final handshake edge.
    run(1'b0, 0, 8'd155, 0, 5);
    run(1'b0, 0, 8'd155, 0, 11);

    // Reset during CAPTURE of word 2.
    sel    = 1'b0;
    hs_cnt = 0;
    push_expected(0);
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_state();
    check_val("hs_before_reset", hs_cnt, 2);
    q_exp.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_val("post_rst_valid", {31'd0, if_a.out_valid}, 32'd0);
    check_val("post_rst_busy",  {31'd0, busy_a}, 32'd0);
    check_val("post_rst_hs",    hs_cnt, 2);
    run(1'b0, 0, 8'd155, 0, 0);

    // Checksum overflow.
    mem[0] = 8'd200; mem[1] = 8'd100; mem[2] = 8'd0; mem[3] = 8'd1;
    run(1'b0, 0, 8'd45, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_readback.md
# ram_readback

Sequential RAM read-back engine on the `init_clock` domain. It is the reading counterpart of the RAM initialisation sequencer. After initialisation completes, a single `start` pulse makes it walk a contiguous window of the 4×8 program RAM, starting at a given address. Each word is delivered on a valid/ready stream to the display/LED path, and the block accumulates a modular checksum so the team can confirm the loaded program image on the board.

## Interface
Parameters:
- `WORDSIZE`, 8, data and checksum width in bits.
- `ADDR_W`, 2, RAM address width; depth is 2^ADDR_W.
- `START_ADDR`, 0, first address read.
- `COUNT`, 4, number of words read per run; legal range is 1..2^ADDR_W.

Ports:
- `init_clock`  in  1  block clock; all state changes on its rising edge.
- `init_reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `ram_addr`  out  ADDR_W  RAM address; registered.
- `ram_write_en`  out  1  RAM write enable; constant 0.
- `ram_data`  in  WORDSIZE  RAM `data_out`; valid one edge after `ram_addr` changes (synchronous read).
- `out_data`  out  WORDSIZE  word being presented.
- `out_addr`  out  ADDR_W  address of `out_data`.
- `out_valid`  out  1  `out_data`/`out_addr` valid.
- `out_ready`  in  1  consumer accepts the word.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  last run completed; level signal.
- `checksum`  out  WORDSIZE  sum of words accepted so far in the current or last run, mod 2^WORDSIZE.

## Operation
- State machine states: IDLE, WAIT, CAPTURE, PRESENT.
- **IDLE**
  - With `start`=1: `ram_addr`<=START_ADDR, index<=0, `checksum`<=0, `done`<=0, go to WAIT.
  - With `start`=0: stay in IDLE; `done` and `checksum` hold.
- **WAIT**: one cycle to cover the RAM read latency. Go to CAPTURE.
- **CAPTURE**: `out_data`<=`ram_data`, `out_addr`<=`ram_addr`, `out_valid`<=1. Go to PRESENT.
- **PRESENT**
  - While `out_ready`=0: hold `out_valid`, `out_data` and `out_addr` stable. No timeout.
  - On handshake (`out_valid`&&`out_ready` at an edge):
    - `out_valid`<=0.
    - `checksum`<=`checksum`+`out_data`, truncated to WORDSIZE.
    - If index==COUNT-1: `done`<=1, go to IDLE.
    - Otherwise: index<=index+1, `ram_addr`<=`ram_addr`+1 (wraps mod 2^ADDR_W), go to WAIT.
- Index counter width is ADDR_W+1, so that COUNT=2^ADDR_W is representable.
- `start` outside IDLE is ignored; it is neither queued nor does it restart the run.
- `start` in the same cycle that the last handshake returns the FSM to IDLE is also ignored; `start` is only sampled one cycle later.
- `ram_write_en` is never asserted. The top-level mux decides when this block owns the RAM address and clock.

## Timing
- Reset values: `ram_addr`=0, `ram_write_en`=0, `out_data`=0, `out_addr`=0, `out_valid`=0, `busy`=0, `done`=0, `checksum`=0, state=IDLE, index=0.
- Reset asserted mid-run aborts immediately and asynchronously to the reset values. No partial word is presented after release.
- Latency: `start` sampled at edge E0 -> `out_valid`=1 after edge E2.
- Throughput with `out_ready` held at 1: one word per 3 cycles. Handshakes occur at E3, E6, E9, E12; with COUNT=4, `done`=1 and `busy`=0 after E12.
- Each cycle of `out_ready`=0 in PRESENT adds exactly one cycle and changes no other output.
- `checksum` updates on the handshake edge, so after the last handshake it is final in the same cycle `done` rises.
- `out_valid` never rises in consecutive cycles; there is at least one WAIT and one CAPTURE cycle between words.

## Test plan
- **Basic read-back**: RAM={74,29,32,20}, defaults, `out_ready`=1, one-cycle `start` -> stream (addr,data)=(0,74),(1,29),(2,32),(3,20); `done`=1 after 13 edges from `start`; `checksum`=155 (0x9B).
- **Wrap-around**: START_ADDR=3, COUNT=4, same RAM -> address order 3,0,1,2 with data 20,74,29,32; `checksum`=155.
- **Backpressure**: `out_ready`=0 for 5 cycles on the second word -> (1,29) is held stable for all 5 cycles; there is exactly one handshake per word; `done` is delayed by exactly 5 cycles; `checksum`=155.
- **Checksum overflow**: RAM={200,100,0,1} -> `checksum`=45 (301 mod 256); `done`=1.
- **Start while busy**: pulse `start` again during PRESENT of word 1 -> no restart, still 4 words in order, single `done`.
- **Reset mid-run**: assert `init_reset` during CAPTURE of word 2 -> all outputs return to reset values immediately; after release, a new `start` replays from address 0 with `checksum` restarting at 0.
